// File: rtl/ap3_pipelined_alu_pkg.sv
// Shared AP3 arithmetic definitions: segment sizing helpers and overflow mode encoding
// for the carry-segmented pipelined add/subtract unit.
package ap3_pipelined_alu_pkg;

  typedef enum logic {
    OVF_UNSIGNED = 1'b0,
    OVF_SIGNED   = 1'b1
  } ovf_mode_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int last_seg_width(input int width, input int sw);
    return width - (ceil_div(width, sw) - 1) * sw;
  endfunction

  // Width of segment k; only the most significant segment may be narrower.
  function automatic int seg_width(input int k, input int width, input int sw);
    if (k == ceil_div(width, sw) - 1) begin
      return last_seg_width(width, sw);
    end else begin
      return sw;
    end
  endfunction

endpackage

// File: rtl/ap3_alu_segment.sv
// One carry-chain segment: ripple add of an SW-bit slice, with its result slice and its
// carry-out registered so the next segment starts from a clean register boundary.
module ap3_alu_segment
  import ap3_pipelined_alu_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ce_i,
  input  logic          carry_i,
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] bb_i,
  output logic [SW-1:0] y_o,
  output logic [SW-1:0] x_o,
  output logic [SW-1:0] co_o,
  output logic          carry_o
);

  logic [SW-1:0] y_d, x_d, co_d;
  logic [SW-1:0] y_q, x_q, co_q;
  logic          carry_q;

  always_comb begin
    logic c;
    c    = carry_i;
    y_d  = '0;
    x_d  = '0;
    co_d = '0;
    for (int i = 0; i < SW; i++) begin
      x_d[i]  = a_i[i] ^ bb_i[i];
      y_d[i]  = x_d[i] ^ c;
      co_d[i] = (a_i[i] & bb_i[i]) | (x_d[i] & c);
      c       = co_d[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      y_q     <= '0;
      x_q     <= '0;
      co_q    <= '0;
      carry_q <= 1'b0;
    end else if (ce_i) begin
      y_q     <= y_d;
      x_q     <= x_d;
      co_q    <= co_d;
      carry_q <= co_d[SW-1];
    end
  end

  assign y_o     = y_q;
  assign x_o     = x_q;
  assign co_o    = co_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/ap3_pipelined_alu.sv
// Registered, carry-segmented $alu equivalent: NSEG segments joined by carry registers,
// with operand skew and result deskew so each operation emerges aligned after NSEG stages.
module ap3_pipelined_alu
  import ap3_pipelined_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8,
  parameter int SIGNED    = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             BI,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] CO,
  output logic             OVF
);

  localparam int        NSEG     = ceil_div(WIDTH, SEG_WIDTH);
  localparam ovf_mode_e OVF_MODE = (SIGNED != 0) ? OVF_SIGNED : OVF_UNSIGNED;

  logic [NSEG-1:0]  valid_q;
  logic [NSEG:0]    carry_s;
  logic [WIDTH-1:0] y_al_s, x_al_s, co_al_s;
  logic             last_bi_s;
  logic             out_bi_q;
  logic             ovf_s;

  assign carry_s[0] = CI;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO   = k * SEG_WIDTH;
    localparam int SW   = seg_width(k, WIDTH, SEG_WIDTH);
    localparam int OPW  = 2 * SW + 1;
    localparam int RESW = 3 * SW;
    localparam int DSK  = NSEG - 1 - k;

    logic [OPW-1:0]  op_s;
    logic [SW-1:0]   bb_s, y_s, x_s, co_s;
    logic [RESW-1:0] res_s;

    if (k == 0) begin : g_direct
      assign op_s = {BI, B[LO +: SW], A[LO +: SW]};
    end else begin : g_skew
      logic [OPW-1:0] skew_q [k];

      // Delay this slice's operands by k stages so they meet their own carry.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int i = 0; i < k; i++) skew_q[i] <= '0;
        end else if (CE) begin
          skew_q[0] <= {BI, B[LO +: SW], A[LO +: SW]};
          for (int i = 1; i < k; i++) skew_q[i] <= skew_q[i-1];
        end
      end

      assign op_s = skew_q[k-1];
    end

    assign bb_s = op_s[OPW-1] ? ~op_s[2*SW-1:SW] : op_s[2*SW-1:SW];

    ap3_alu_segment #(.SW(SW)) u_seg (
      .clk_i   (CLK),
      .rst_i   (RST),
      .ce_i    (CE),
      .carry_i (carry_s[k]),
      .a_i     (op_s[SW-1:0]),
      .bb_i    (bb_s),
      .y_o     (y_s),
      .x_o     (x_s),
      .co_o    (co_s),
      .carry_o (carry_s[k+1])
    );

    if (DSK == 0) begin : g_nodeskew
      assign res_s = {co_s, x_s, y_s};
    end else begin : g_deskew
      logic [RESW-1:0] deskew_q [DSK];

      // Hold early segments back until the most significant slice catches up.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int i = 0; i < DSK; i++) deskew_q[i] <= '0;
        end else if (CE) begin
          deskew_q[0] <= {co_s, x_s, y_s};
          for (int i = 1; i < DSK; i++) deskew_q[i] <= deskew_q[i-1];
        end
      end

      assign res_s = deskew_q[DSK-1];
    end

    assign y_al_s[LO +: SW]  = res_s[SW-1:0];
    assign x_al_s[LO +: SW]  = res_s[2*SW-1:SW];
    assign co_al_s[LO +: SW] = res_s[3*SW-1:2*SW];

    if (k == NSEG - 1) begin : g_last_bi
      assign last_bi_s = op_s[OPW-1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q  <= '0;
      out_bi_q <= 1'b0;
    end else if (CE) begin
      valid_q[0] <= IN_VALID;
      for (int i = 1; i < NSEG; i++) valid_q[i] <= valid_q[i-1];
      out_bi_q   <= last_bi_s;
    end
  end

  // The last segment has no deskew, so its carry register is the aligned CO MSB.
  always_comb begin
    case (OVF_MODE)
      OVF_SIGNED:   ovf_s = co_al_s[WIDTH-1] ^ co_al_s[WIDTH-2];
      OVF_UNSIGNED: ovf_s = carry_s[NSEG] ^ out_bi_q;
      default:      ovf_s = 1'b0;
    endcase
  end

  assign OUT_VALID = valid_q[NSEG-1];
  assign X         = x_al_s;
  assign Y         = y_al_s;
  assign CO        = co_al_s;
  assign OVF       = ovf_s;

endmodule

// File: tb/tb_ap3_pipelined_alu.sv
// Scoreboard bench for ap3_pipelined_alu: three instances (32/8 unsigned, 32/8 signed,
// 12/5 unsigned) driven by directed vectors; monitors pop expected results on each output.
module tb_ap3_pipelined_alu;

  typedef struct {
    logic [31:0] y;
    logic [31:0] x;
    logic [31:0] co;
    logic        ovf;
    longint      edge_n;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst, ce;
  logic   ce_q = 1'b0;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  logic        va, vs, vn;
  logic [31:0] a_a, b_a, a_s, b_s;
  logic [11:0] a_n, b_n;
  logic        ci_a, bi_a, ci_s, bi_s, ci_n, bi_n;
  logic        ov_a, ov_s, ov_n, f_a, f_s, f_n;
  logic [31:0] y_a, x_a, co_a, y_s, x_s, co_s;
  logic [11:0] y_n, x_n, co_n;

  exp_t q_a[$], q_s[$], q_n[$];
  exp_t ea, es, en, e2;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    ce_q <= ce;
  end

  ap3_pipelined_alu #(.WIDTH(32), .SEG_WIDTH(8), .SIGNED(0)) u_a (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(va), .A(a_a), .B(b_a), .CI(ci_a), .BI(bi_a),
    .OUT_VALID(ov_a), .X(x_a), .Y(y_a), .CO(co_a), .OVF(f_a));

  ap3_pipelined_alu #(.WIDTH(32), .SEG_WIDTH(8), .SIGNED(1)) u_s (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(vs), .A(a_s), .B(b_s), .CI(ci_s), .BI(bi_s),
    .OUT_VALID(ov_s), .X(x_s), .Y(y_s), .CO(co_s), .OVF(f_s));

  ap3_pipelined_alu #(.WIDTH(12), .SEG_WIDTH(5), .SIGNED(0)) u_n (
    .CLK(clk), .RST(rst), .CE(ce), .IN_VALID(vn), .A(a_n), .B(b_n), .CI(ci_n), .BI(bi_n),
    .OUT_VALID(ov_n), .X(x_n), .Y(y_n), .CO(co_n), .OVF(f_n));

  function automatic exp_t mk(input logic [31:0] y, x, co, input logic ovf);
    exp_t e;
    e.y = y; e.x = x; e.co = co; e.ovf = ovf; e.edge_n = 0;
    return e;
  endfunction

  // Reference: whole-word addition; carries recovered from sum ^ (A ^ BB).
  function automatic exp_t model(input logic [31:0] a, b, input logic ci, bi,
                                 input int w, input bit sgn);
    exp_t        e;
    logic [63:0] mask, aa, bb, full;
    logic [31:0] cin;
    mask = (64'd1 << w) - 64'd1;
    aa   = {32'd0, a} & mask;
    bb   = (bi ? ~{32'd0, b} : {32'd0, b}) & mask;
    full = aa + bb + {63'd0, ci};
    e.y  = full[31:0] & mask[31:0];
    e.x  = aa[31:0] ^ bb[31:0];
    cin  = e.y ^ e.x;
    e.co = ((cin >> 1) | ({31'd0, full[w]} << (w - 1))) & mask[31:0];
    e.ovf = sgn ? (e.co[w-1] ^ e.co[w-2]) : (full[w] ^ bi);
    e.edge_n = 0;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] y, x, co, input logic ovf, input exp_t e);
    checks++;
    if (y !== e.y || x !== e.x || co !== e.co || ovf !== e.ovf || cyc != e.edge_n) begin
      errors++;
      $display("FAIL %s: got Y=%h X=%h CO=%h OVF=%b edge=%0d, want Y=%h X=%h CO=%h OVF=%b edge=%0d",
               nm, y, x, co, ovf, cyc, e.y, e.x, e.co, e.ovf, e.edge_n);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] y);
    checks++;
    errors++;
    $display("FAIL %s: got OUT_VALID=1 Y=%h, want no result", nm, y);
  endtask

  // Monitors: a new result is one presented after an enabled edge.
  always @(negedge clk) begin
    if (!rst && ce_q && ov_a) begin
      if (q_a.size() == 0) unexpected("a_unexpected", y_a);
      else begin
        ea = q_a.pop_front();
        cmp("a_result", y_a, x_a, co_a, f_a, ea);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ce_q && ov_s) begin
      if (q_s.size() == 0) unexpected("s_unexpected", y_s);
      else begin
        es = q_s.pop_front();
        cmp("s_result", y_s, x_s, co_s, f_s, es);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ce_q && ov_n) begin
      if (q_n.size() == 0) unexpected("n_unexpected", {20'd0, y_n});
      else begin
        en = q_n.pop_front();
        cmp("n_result", {20'd0, y_n}, {20'd0, x_n}, {20'd0, co_n}, f_n, en);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input logic [31:0] a, b, input logic ci, bi, input exp_t e,
                         input int extra, input bit push);
    a_a = a; b_a = b; ci_a = ci; bi_a = bi; va = 1'b1;
    e.edge_n = cyc + 4 + extra;
    if (push) q_a.push_back(e);
    tick();
    va = 1'b0;
  endtask

  task automatic issue_s(input logic [31:0] a, b, input logic ci, bi, input exp_t e);
    a_s = a; b_s = b; ci_s = ci; bi_s = bi; vs = 1'b1;
    e.edge_n = cyc + 4;
    q_s.push_back(e);
    tick();
    vs = 1'b0;
  endtask

  task automatic issue_n(input logic [11:0] a, b, input logic ci, bi, input exp_t e);
    a_n = a; b_n = b; ci_n = ci; bi_n = bi; vn = 1'b1;
    e.edge_n = cyc + 3;
    q_n.push_back(e);
    tick();
    vn = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q_a.size() + q_s.size() + q_n.size()) != 0 && t < 40) begin
      tick();
      t++;
    end
    checks++;
    if ((q_a.size() + q_s.size() + q_n.size()) != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, want 0",
               q_a.size() + q_s.size() + q_n.size());
      q_a.delete(); q_s.delete(); q_n.delete();
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rci, rbi;
    rst = 1'b1; ce = 1'b1; va = 1'b0; vs = 1'b0; vn = 1'b0;
    a_a = '0; b_a = '0; a_s = '0; b_s = '0; a_n = '0; b_n = '0;
    ci_a = 1'b0; bi_a = 1'b0; ci_s = 1'b0; bi_s = 1'b0; ci_n = 1'b0; bi_n = 1'b0;
    repeat (2) tick();
    chk("rst_a_valid", {31'd0, ov_a}, 32'd0);
    chk("rst_a_y", y_a, 32'd0);
    chk("rst_a_co", co_a, 32'd0);
    chk("rst_a_ovf", {31'd0, f_a}, 32'd0);
    chk("rst_n_xy", {8'd0, x_n, y_n}, 32'd0);
    rst = 1'b0;

    // Full carry ripple, issued on the first edge after reset release.
    issue_a(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0,
            mk(32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1), 0, 1'b1);
    drain();

    // Subtract with and without borrow.
    issue_a(32'd5, 32'd7, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, 1'b1), 0, 1'b1);
    issue_a(32'd7, 32'd5, 1'b1, 1'b1, mk(32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), 0, 1'b1);
    issue_a(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0,
            mk(32'h8000_0000, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b0), 0, 1'b1);
    issue_s(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, mk(32'h8000_0000, 32'h7FFF_FFFE, 32'h7FFF_FFFF, 1'b1));
    issue_s(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, mk(32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0));
    drain();

    // Streaming: 8 back-to-back, 2 bubbles, 4 more.
    for (int i = 0; i < 12; i++) begin
      if (i == 8) begin
        va = 1'b0;
        repeat (2) tick();
      end
      ra = $urandom; rb = $urandom; rci = 1'($urandom); rbi = 1'($urandom);
      issue_a(ra, rb, rci, rbi, model(ra, rb, rci, rbi, 32, 1'b0), 0, 1'b1);
    end
    drain();

    // Stall three edges with three operations still inside the pipeline.
    for (int i = 0; i < 5; i++) begin
      ra = $urandom; rb = $urandom; rci = 1'($urandom); rbi = 1'($urandom);
      if (i == 1) e2 = model(ra, rb, rci, rbi, 32, 1'b0);
      issue_a(ra, rb, rci, rbi, model(ra, rb, rci, rbi, 32, 1'b0), (i < 2) ? 0 : 3, 1'b1);
    end
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, ov_a}, 32'd1);
      chk("stall_y", y_a, e2.y);
      @(posedge clk);
      #1;
    end
    ce = 1'b1;
    drain();

    // Reset with three operations in flight: nothing may complete afterwards.
    for (int i = 0; i < 3; i++) issue_a(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, mk(0, 0, 0, 0), 0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, ov_a}, 32'd0);
    chk("midrst_y", y_a, 32'd0);
    chk("midrst_x", x_a, 32'd0);
    chk("midrst_co", co_a, 32'd0);
    chk("midrst_ovf", {31'd0, f_a}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, ov_a}, 32'd0);
      @(posedge clk);
      #1;
    end

    // Uneven 5/5/2 segmentation.
    issue_n(12'hFFF, 12'h001, 1'b0, 1'b0, mk(32'h000, 32'hFFE, 32'hFFF, 1'b1));
    issue_n(12'h01F, 12'h001, 1'b0, 1'b0, mk(32'h020, 32'h01E, 32'h01F, 1'b0));
    issue_n(12'h3FF, 12'h001, 1'b0, 1'b0, mk(32'h400, 32'h3FE, 32'h3FF, 1'b0));
    issue_n(12'h000, 12'h001, 1'b1, 1'b1, mk(32'hFFF, 32'hFFE, 32'h000, 1'b1));
    for (int i = 0; i < 1000; i++) begin
      ra = {20'd0, 12'($urandom)}; rb = {20'd0, 12'($urandom)};
      rci = 1'($urandom); rbi = 1'($urandom);
      issue_n(ra[11:0], rb[11:0], rci, rbi, model(ra, rb, rci, rbi, 12, 1'b0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion by %0t, want finish", $time);
    $fatal(1, "timeout");
  end

endmodule
